// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: decode handshake, execute redirect and instruction-memory port.
// FETCH_BIOS_EN adds the bios_rdata return path.
interface fetch_stage_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
`ifdef FETCH_BIOS_EN
    logic [31:0] bios_rdata;
`endif
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        fetch_misaligned;
    logic [31:0] fetch_count;

`ifdef FETCH_BIOS_EN
    modport master (
        input  stall, redirect, redirect_pc, imem_rdata, bios_rdata,
        output imem_addr, inst, inst_pc, inst_valid, fetch_misaligned, fetch_count
    );
    modport slave (
        output stall, redirect, redirect_pc, imem_rdata, bios_rdata,
        input  imem_addr, inst, inst_pc, inst_valid, fetch_misaligned, fetch_count
    );
`else
    modport master (
        input  stall, redirect, redirect_pc, imem_rdata,
        output imem_addr, inst, inst_pc, inst_valid, fetch_misaligned, fetch_count
    );
    modport slave (
        output stall, redirect, redirect_pc, imem_rdata,
        input  imem_addr, inst, inst_pc, inst_valid, fetch_misaligned, fetch_count
    );
`endif
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle-latency instruction memory.
// Optional FETCH_BIOS_EN: instructions with PC bit 30 set come from bios_rdata.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        valid_q;
    logic        miss_q, miss_d;
    logic [31:0] count_q, count_d;
    logic        inst_valid;

    assign inst_valid = valid_q & ~bus.redirect & ~rst;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        if (rst) begin
            fetch_pc_d = RESET_PC;
        end else if (bus.redirect) begin
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
        end else if (!valid_q || bus.stall) begin
            // Re-issuing the same address returns the same word on the next cycle.
            fetch_pc_d = fetch_pc_q;
        end

        miss_d = miss_q | (bus.redirect & (bus.redirect_pc[1:0] != 2'b00));

        count_d = count_q;
        if (inst_valid && !bus.stall) begin
            count_d = count_q + 32'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            valid_q    <= 1'b0;
            miss_q     <= 1'b0;
            count_q    <= 32'd0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            valid_q    <= 1'b1;
            miss_q     <= miss_d;
            count_q    <= count_d;
        end
    end

    assign bus.imem_addr        = fetch_pc_d;
    assign bus.inst_pc          = fetch_pc_q;
    assign bus.inst_valid       = inst_valid;
    assign bus.fetch_misaligned = miss_q;
    assign bus.fetch_count      = count_q;

`ifdef FETCH_BIOS_EN
    // The registered PC lines up with the word returning from last cycle's address.
    assign bus.inst = fetch_pc_q[30] ? bus.bios_rdata : bus.imem_rdata;
`else
    assign bus.inst = bus.imem_rdata;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory returns word = address (BIOS returns ~address).
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h4000_0000;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories: data for the address issued this cycle returns next cycle.
    always @(posedge clk) begin
        bus.imem_rdata <= bus.imem_addr;
`ifdef FETCH_BIOS_EN
        bus.bios_rdata <= ~bus.imem_addr;
`endif
    end

    function automatic logic [31:0] exp_word(input logic [31:0] addr);
`ifdef FETCH_BIOS_EN
        return addr[30] ? ~addr : addr;
`else
        return addr;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one cycle: drive inputs just after the rising edge, then wait for the falling edge.
    task automatic cyc(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        rst             = r;
        bus.stall       = s;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        @(negedge clk);
    endtask

    task automatic chk_inst(input string tag, input logic [31:0] pc, input logic v, input logic [31:0] cnt);
        check({tag, ".pc"},    bus.inst_pc, pc);
        check({tag, ".valid"}, {31'd0, bus.inst_valid}, {31'd0, v});
        check({tag, ".cnt"},   bus.fetch_count, cnt);
        if (v) check({tag, ".inst"}, bus.inst, exp_word(pc));
    endtask

    initial begin
        rst             = 1'b1;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        bus.imem_rdata  = 32'd0;
`ifdef FETCH_BIOS_EN
        bus.bios_rdata  = 32'd0;
`endif

        // Reset state
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        check("rst.valid", {31'd0, bus.inst_valid}, 32'd0);
        check("rst.miss",  {31'd0, bus.fetch_misaligned}, 32'd0);
        check("rst.cnt",   bus.fetch_count, 32'd0);
        check("rst.addr",  bus.imem_addr, RST_PC);
        check("rst.pc",    bus.inst_pc, RST_PC);

        // Free run: bubble then one instruction per cycle
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        check("c1.valid", {31'd0, bus.inst_valid}, 32'd0);
        check("c1.addr",  bus.imem_addr, RST_PC);
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        chk_inst("c2", 32'h4000_0000, 1'b1, 32'd0);
        check("c2.addr", bus.imem_addr, 32'h4000_0004);
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        chk_inst("c3", 32'h4000_0004, 1'b1, 32'd1);

        // Stall three cycles on 0x4000_0008
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        chk_inst("c4", 32'h4000_0008, 1'b1, 32'd2);
        check("c4.addr", bus.imem_addr, 32'h4000_0008);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'd0);
            chk_inst("stall", 32'h4000_0008, 1'b1, 32'd2);
        end
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        chk_inst("unstall", 32'h4000_0008, 1'b1, 32'd2);
        check("unstall.addr", bus.imem_addr, 32'h4000_000C);

        // Redirect wins over stall
        cyc(1'b0, 1'b1, 1'b1, 32'h1000_0020);
        chk_inst("redir", 32'h4000_000C, 1'b0, 32'd3);
        check("redir.addr", bus.imem_addr, 32'h1000_0020);
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        chk_inst("tgt", 32'h1000_0020, 1'b1, 32'd3);
        check("tgt.miss", {31'd0, bus.fetch_misaligned}, 32'd0);

        // Misaligned redirect: aligned fetch, sticky flag
        cyc(1'b0, 1'b0, 1'b1, 32'h1000_0022);
        check("mis.addr",  bus.imem_addr, 32'h1000_0020);
        check("mis.valid", {31'd0, bus.inst_valid}, 32'd0);
        check("mis.flag0", {31'd0, bus.fetch_misaligned}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        chk_inst("mis1", 32'h1000_0020, 1'b1, 32'd4);
        check("mis.flag1", {31'd0, bus.fetch_misaligned}, 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        chk_inst("mis2", 32'h1000_0024, 1'b1, 32'd5);
        check("mis.flag2", {31'd0, bus.fetch_misaligned}, 32'd1);

        // Counter wrap: preload all-ones during a stalled cycle
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        chk_inst("pre", 32'h1000_0028, 1'b1, 32'd6);
        force dut.count_q = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.count_q;
        bus.stall = 1'b0;
        @(negedge clk);
        chk_inst("wrap0", 32'h1000_0028, 1'b1, 32'hFFFF_FFFF);
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        chk_inst("wrap1", 32'h1000_002C, 1'b1, 32'd0);

        // Reset mid-stream with stall and a misaligned redirect pending
        cyc(1'b1, 1'b1, 1'b1, 32'h2000_0003);
        check("mrst.addr",  bus.imem_addr, RST_PC);
        check("mrst.valid", {31'd0, bus.inst_valid}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        chk_inst("mrst1", RST_PC, 1'b0, 32'd0);
        check("mrst.miss", {31'd0, bus.fetch_misaligned}, 32'd0);
        check("mrst.addr1", bus.imem_addr, RST_PC);
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        chk_inst("mrst2", RST_PC, 1'b1, 32'd0);

        // BIOS region to low memory: inst source follows inst_pc
        cyc(1'b0, 1'b0, 1'b1, 32'h4000_0100);
        check("b.valid", {31'd0, bus.inst_valid}, 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0040);
        check("b1.pc",   bus.inst_pc, 32'h4000_0100);
        check("b1.inst", bus.inst, exp_word(32'h4000_0100));
        check("b1.valid", {31'd0, bus.inst_valid}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        chk_inst("b2", 32'h0000_0040, 1'b1, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
